// File: rtl/rom_sequencer_pkg.sv
// Shared definitions for the microinstruction ROM sequencer: field layout,
// ALU op codes, FSM state encoding and the halt word.
package rom_sequencer_pkg;

  localparam int unsigned IR_W = 26;

  localparam int unsigned RA_HI      = 25;
  localparam int unsigned RA_LO      = 22;
  localparam int unsigned RB_HI      = 21;
  localparam int unsigned RB_LO      = 18;
  localparam int unsigned RW_HI      = 17;
  localparam int unsigned RW_LO      = 14;
  localparam int unsigned WE_BIT     = 13;
  localparam int unsigned IMM_SEL_BIT = 12;
  localparam int unsigned AUX_BIT    = 11;
  localparam int unsigned OP_HI      = 10;
  localparam int unsigned OP_LO      = 8;
  localparam int unsigned IMM_HI     = 7;
  localparam int unsigned IMM_LO     = 0;

  typedef enum logic [2:0] {
    AluAdd  = 3'd0,
    AluSub  = 3'd1,
    AluAnd  = 3'd2,
    AluOr   = 3'd3,
    AluXor  = 3'd4,
    AluShl  = 3'd5,
    AluShr  = 3'd6,
    AluPass = 3'd7
  } alu_op_e;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StExec  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [IR_W-1:0] HALT_WORD = '0;

endpackage

// File: rtl/rom_sequencer_if.sv
// ROM read port plus decoded datapath controls and status of the sequencer.
interface rom_sequencer_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 26
);
  logic              start;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [3:0]        ra_addr;
  logic [3:0]        rb_addr;
  logic [3:0]        rw_addr;
  logic              reg_we;
  logic              imm_sel;
  logic              aux;
  logic [2:0]        alu_op;
  logic [7:0]        imm;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              done;

  modport master (
    input  start, rom_data,
    output rom_addr, ra_addr, rb_addr, rw_addr, reg_we, imm_sel, aux, alu_op, imm, pc, busy,
           done
  );

  modport slave (
    output start, rom_data,
    input  rom_addr, ra_addr, rb_addr, rw_addr, reg_we, imm_sel, aux, alu_op, imm, pc, busy,
           done
  );
endinterface

// File: rtl/microinst_decode.sv
// Pure combinational split of a 26-bit microinstruction into its control fields.
module microinst_decode
  import rom_sequencer_pkg::*;
(
  input  logic [IR_W-1:0] ir,
  output logic [3:0]      ra_addr,
  output logic [3:0]      rb_addr,
  output logic [3:0]      rw_addr,
  output logic            we_bit,
  output logic            imm_sel,
  output logic            aux,
  output logic [2:0]      alu_op,
  output logic [7:0]      imm
);

  always_comb begin
    ra_addr = ir[RA_HI:RA_LO];
    rb_addr = ir[RB_HI:RB_LO];
    rw_addr = ir[RW_HI:RW_LO];
    we_bit  = ir[WE_BIT];
    imm_sel = ir[IMM_SEL_BIT];
    aux     = ir[AUX_BIT];
    alu_op  = ir[OP_HI:OP_LO];
    imm     = ir[IMM_HI:IMM_LO];
  end

endmodule

// File: rtl/rom_sequencer.sv
// Steps a PC through the microinstruction ROM, latches each word into IR and
// drives decoded controls; two cycles per instruction, one program per start.
module rom_sequencer
  import rom_sequencer_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 6,
  parameter int unsigned       DATA_W     = 26,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input logic               clk,
  input logic               rst,
  rom_sequencer_if.master   bus
);

  localparam logic [ADDR_W-1:0] PcLast = '1;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              we_bit;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StFetch;
          pc_d    = START_ADDR;
        end
      end
      StFetch: begin
        // A halt word ends the program without disturbing IR.
        if (bus.rom_data == HALT_WORD) begin
          state_d = StDone;
        end else begin
          ir_d    = bus.rom_data;
          state_d = StExec;
        end
      end
      StExec: begin
        pc_d    = pc_q + 1'b1;
        state_d = (pc_q == PcLast) ? StDone : StFetch;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= START_ADDR;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  microinst_decode u_decode (
    .ir      (ir_q),
    .ra_addr (bus.ra_addr),
    .rb_addr (bus.rb_addr),
    .rw_addr (bus.rw_addr),
    .we_bit  (we_bit),
    .imm_sel (bus.imm_sel),
    .aux     (bus.aux),
    .alu_op  (bus.alu_op),
    .imm     (bus.imm)
  );

  always_comb begin
    bus.rom_addr = pc_q;
    bus.pc       = pc_q;
    bus.reg_we   = we_bit && (state_q == StExec);
    bus.busy     = (state_q == StFetch) || (state_q == StExec);
    bus.done     = (state_q == StDone);
  end

endmodule

// File: doc/rom_sequencer.md
Name: rom_sequencer

Overview:
- Reader/controller side of the 26-bit microinstruction ROM.
- Steps a 6-bit program counter through ROM addresses, latches each word into an instruction register, and decodes it into datapath control signals:
  - register-file read/write addresses,
  - write enable,
  - immediate select,
  - ALU op,
  - 8-bit immediate.
- Sits between the ROM and the register-file/ALU datapath.
- Runs one program per start pulse and reports completion.

Parameters:
- ADDR_W, 6, ROM address width; PC wraps modulo 2^ADDR_W.
- DATA_W, 26, microinstruction width; field layout is fixed for 26.
- START_ADDR, 0, PC value loaded on each start.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin program execution; sampled only in IDLE.
- rom_addr  out  ADDR_W  address to ROM (combinational-read ROM).
- rom_data  in  DATA_W  word returned by ROM for rom_addr in the same cycle.
- ra_addr  out  4  read port A address = IR[25:22].
- rb_addr  out  4  read port B address = IR[21:18].
- rw_addr  out  4  write address = IR[17:14].
- reg_we  out  1  register write enable; IR[13] qualified by EXEC state.
- imm_sel  out  1  ALU B operand selects immediate = IR[12].
- aux  out  1  spare control bit = IR[11], passed through.
- alu_op  out  3  ALU operation = IR[10:8].
- imm  out  8  immediate = IR[7:0].
- pc  out  ADDR_W  current program counter.
- busy  out  1  high in FETCH and EXEC.
- done  out  1  one-cycle pulse when the program ends.

Behaviour:
- States:
  - IDLE: pc holds; IR holds its last value; busy=0.
    - If start=1, go to FETCH and load pc=START_ADDR.
  - FETCH: rom_addr=pc; IR <= rom_data at the clock edge.
    - If rom_data == 0 (halt word), go to DONE and leave IR unchanged.
    - Otherwise go to EXEC.
  - EXEC: decoded fields are driven from IR; reg_we = IR[13] for exactly this cycle.
    - pc <= pc+1 at the edge.
    - If pc == 2^ADDR_W-1, go to DONE with no wrap execution; otherwise go to FETCH.
  - DONE: done=1 for one cycle, then IDLE.
- Field outputs are always decoded from IR in every state. reg_we is 0 outside EXEC.
- rom_addr = pc in all states.
- Throughput: 2 cycles per instruction.
  - If start is sampled at edge k, instruction i has FETCH in cycle k+1+2i and EXEC in cycle k+2+2i.
- start is ignored while busy or in DONE.
  - start held high continuously re-launches the program after every IDLE cycle.
- Reset (any state, including mid-program) sets: state=IDLE, pc=START_ADDR, IR=0, and busy=done=reg_we=0. All decoded outputs are therefore 0. No partial instruction completes.
- An all-zero word at START_ADDR produces done 2 cycles after start is sampled, with no reg_we pulse.

Decomposition:
- Shared package holds:
  - field-position localparams (RA_HI/LO=25/22, RB=21/18, RW=17/14, WE=13, IMM_SEL=12, AUX=11, OP=10/8, IMM=7/0),
  - ALU op encodings,
  - state encoding (IDLE, FETCH, EXEC, DONE),
  - the HALT_WORD constant 0.
- One natural sub-module: microinst_decode. It is purely combinational, maps the 26-bit IR to the field outputs, and is reused by any future pipelined sequencer.
- The FSM, pc and IR stay in rom_sequencer.

Test Plan:
1. Reset then idle: rst high 2 cycles, start=0 → all outputs 0, pc=0, rom_addr=0, busy=0 for 10 cycles.
2. Six-instruction program plus zero word at address 6, start pulse at edge k:
   - reg_we pulses at cycles k+2, k+4, ..., k+12;
   - at cycle k+2: rw_addr=0, imm_sel=1, imm=0x7D;
   - at cycle k+8: ra=0, rb=1, rw=10, imm_sel=0, alu_op=6;
   - done pulses at cycle k+14; IDLE at k+15.
3. Halt word at address 0 → done pulses at k+2; reg_we never asserts; pc stays 0.
4. Instruction with IR[13]=0 (e.g. 0x0000100) → reg_we stays 0 during its EXEC; imm=0x00 and alu_op=1 are still driven.
5. rst asserted during the EXEC of the 3rd instruction → next cycle: IDLE, pc=0, all outputs 0, no done pulse; a later start reruns from address 0.
6. All 64 words nonzero → 64 reg_we pulses; done at cycle k+129; pc ends at 0 with no 65th fetch. start pulses while busy have no effect.
